cdb_arbiter: RTL

Writeback arbiter between the two result producers (reservation-station ALU and load/store buffer) and the single common data bus that updates the reorder buffer and broadcasts to RS/LSB. Each source gets a small skid FIFO so a losing result is never lost. Grant is round-robin. Output is one registered CDB beat per cycle. The block flushes on ROB misprediction clear.

---
 rtl/cdb_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Round-robin writeback arbiter (ALU / LSB) onto one registered CDB,
//            with a per-source skid FIFO and bypass when the FIFO is empty.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cdb_arbiter #(
    parameter int ROB_INDEX_BIT = 4,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,
    input  logic                     alu_ready_in,
    input  logic [ROB_INDEX_BIT-1:0] alu_rob_id_in,
    input  logic [31:0]              alu_result_in,
    input  logic                     lsb_ready_in,
    input  logic [ROB_INDEX_BIT-1:0] lsb_rob_id_in,
    input  logic [31:0]              lsb_result_in,
    output logic                     alu_stall_out,
    output logic                     lsb_stall_out,
    output logic                     cdb_ready_out,
    output logic [ROB_INDEX_BIT-1:0] cdb_rob_id_out,
    output logic [31:0]              cdb_result_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [ROB_INDEX_BIT-1:0] id;
        logic [31:0]              data;
    } beat_t;

    // Source index 0 is the ALU, 1 is the LSB (matches last_grant encoding).
    logic [1:0] w_in_vld;
    beat_t      w_in   [2];
    beat_t      w_head [2];
    logic [1:0] w_full;
    logic [1:0] w_has_q;
    logic [1:0] w_cand;
    logic [1:0] w_pop;
    logic [1:0] w_bypass;
    logic [1:0] w_push;

    logic  w_any;
    logic  w_win;
    beat_t w_sel;

    logic  r_last_grant;
    logic  r_cdb_vld;
    beat_t r_cdb;

    assign w_in_vld = {lsb_ready_in, alu_ready_in};
    assign w_in[0]  = {alu_rob_id_in, alu_result_in};
    assign w_in[1]  = {lsb_rob_id_in, lsb_result_in};

    always_comb begin
        w_any = |w_cand;
        w_win = (&w_cand) ? ~r_last_grant : w_cand[1];
        w_sel = w_has_q[w_win] ? w_head[w_win] : w_in[w_win];
    end

    generate
        for (genvar s = 0; s < 2; s++) begin : g_src
            beat_t            r_mem [FIFO_DEPTH];
            logic [PTR_W-1:0] r_head;
            logic [PTR_W-1:0] r_tail;
            logic [CNT_W-1:0] r_cnt;
            logic             w_mine;

            assign w_full[s]   = (r_cnt == C_FULL);
            assign w_has_q[s]  = (r_cnt != '0);
            assign w_cand[s]   = w_has_q[s] | w_in_vld[s];
            assign w_head[s]   = r_mem[r_head];
            assign w_mine      = w_any && (w_win == 1'(s));
            assign w_pop[s]    = w_mine && w_has_q[s];
            assign w_bypass[s] = w_mine && !w_has_q[s];
            // A push against a full FIFO is dropped even if it pops this cycle.
            assign w_push[s]   = w_in_vld[s] && !w_bypass[s] && !w_full[s];

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    r_head <= '0;
                    r_tail <= '0;
                    r_cnt  <= '0;
                end else if (rdy_in) begin
                    if (clear_in) begin
                        r_head <= '0;
                        r_tail <= '0;
                        r_cnt  <= '0;
                    end else begin
                        if (w_pop[s])  r_head <= r_head + 1'b1;
                        if (w_push[s]) r_tail <= r_tail + 1'b1;
                        r_cnt <= r_cnt + CNT_W'(w_push[s]) - CNT_W'(w_pop[s]);
                    end
                end
            end

            always_ff @(posedge clk_in) begin
                if (rdy_in && !clear_in && w_push[s]) begin
                    r_mem[r_tail] <= w_in[s];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_last_grant <= 1'b1;
            r_cdb_vld    <= 1'b0;
            r_cdb        <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                r_last_grant <= 1'b1;
                r_cdb_vld    <= 1'b0;
            end else begin
                r_cdb_vld <= w_any;
                if (w_any) begin
                    r_cdb        <= w_sel;
                    r_last_grant <= w_win;
                end
            end
        end
    end

    assign alu_stall_out  = w_full[0];
    assign lsb_stall_out  = w_full[1];
    assign cdb_ready_out  = r_cdb_vld;
    assign cdb_rob_id_out = r_cdb.id;
    assign cdb_result_out = r_cdb.data;

endmodule

`default_nettype wire
